register_vector: RTL

Vector register file for the vector datapath: NREGS registers of LANES × WIDTH bits, three combinational read ports, one masked write port with scalar-broadcast mode, same-cycle write-to-read bypass, and a per-register busy scoreboard for hazard detection. It extends the scalar register file's 3-read/1-write organisation to vector operands. It sits between decode (issue/scoreboard) and the vector lanes and writeback (write port).

---
 rtl/vector_pkg.sv | 21 ++
 rtl/register_scoreboard.sv | 64 ++++++
 rtl/register_vector.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
// Shared constants and types for the vector register file.
//   WIDTH      : bits per lane element
//   LANES      : elements per vector register
//   NREGS      : number of vector registers (power of two)
//   reg_addr_t : register index
//   elem_t     : one lane element
//   vec_t      : one full vector register, lane i at index i
// ---------------------------------------------------------------------------
package vector_pkg;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int NREGS = 16;

  typedef logic [$clog2(NREGS)-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]         elem_t;
  typedef elem_t [LANES-1:0]        vec_t;

endpackage

// File: rtl/register_scoreboard.sv
// ---------------------------------------------------------------------------
// register_scoreboard
// Per-register busy bits used by decode for hazard detection.
//   clk, rst        : clock, asynchronous active-high reset (clears all bits)
//   clr_valid/addr  : writeback commit, clears busy[clr_addr]
//   set_valid/addr  : instruction issue, sets busy[set_addr]
//   flush           : clears every bit, discards a same-cycle issue
//   rs1..rs3        : read-port addresses to look up
//   busy1..busy3    : registered busy bit of rs1..rs3
//   busy_rd         : registered busy bit of set_addr (WAW check)
// ---------------------------------------------------------------------------
module register_scoreboard
  import vector_pkg::*;
#(
  parameter int NREGS    = vector_pkg::NREGS,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_valid,
  input  logic [AW-1:0] clr_addr,
  input  logic          set_valid,
  input  logic [AW-1:0] set_addr,
  input  logic          flush,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rs3,
  output logic          busy1,
  output logic          busy2,
  output logic          busy3,
  output logic          busy_rd
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy state. The clear is applied before the set so that an
  // instruction issuing to the register being written back keeps it busy.
  // Flush overrides both. A hardwired zero register is never busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_valid) busy_d[clr_addr] = 1'b0;
      if (set_valid) busy_d[set_addr] = 1'b1;
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  // Busy storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Lookups read registered state only; same-cycle set/clear is not bypassed.
  assign busy1   = busy_q[rs1];
  assign busy2   = busy_q[rs2];
  assign busy3   = busy_q[rs3];
  assign busy_rd = busy_q[set_addr];

endmodule

// File: rtl/register_vector.sv
// ---------------------------------------------------------------------------
// register_vector
// Vector register file: NREGS registers of LANES x WIDTH bits, three
// combinational read ports with per-lane write bypass, one masked write port
// with scalar broadcast, and a busy scoreboard.
//   clk, rst          : clock, asynchronous active-high reset
//   RS1..RS3          : read addresses,   RD1..RD3 : read data
//   RD, WD, WD_S      : write address, vector data, scalar broadcast data
//   wr_enable/mask    : write commit and per-lane enables
//   wr_broadcast      : write WD_S into every masked lane
//   issue_valid/rd    : mark destination busy
//   flush             : clear all busy bits
//   busy1..3, busy_rd : busy bits of RS1..RS3 and issue_rd
// ---------------------------------------------------------------------------
module register_vector
  import vector_pkg::*;
#(
  parameter int WIDTH    = vector_pkg::WIDTH,
  parameter int LANES    = vector_pkg::LANES,
  parameter int NREGS    = vector_pkg::NREGS,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(NREGS),
  localparam int VW      = LANES * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    RS1,
  input  logic [AW-1:0]    RS2,
  input  logic [AW-1:0]    RS3,
  input  logic [AW-1:0]    RD,
  input  logic [VW-1:0]    WD,
  input  logic [WIDTH-1:0] WD_S,
  input  logic             wr_enable,
  input  logic [LANES-1:0] wr_mask,
  input  logic             wr_broadcast,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             flush,
  output logic [VW-1:0]    RD1,
  output logic [VW-1:0]    RD2,
  output logic [VW-1:0]    RD3,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3,
  output logic             busy_rd
);

  logic [VW-1:0] regs_q [NREGS];
  logic [VW-1:0] regs_d [NREGS];
  logic [VW-1:0] wr_data_eff;
  logic          wr_allowed;
  logic [AW-1:0] rs_addr [3];
  logic [VW-1:0] rd_data [3];

  // Per-lane write data: the scalar operand replicated, or the vector lane.
  always_comb begin
    wr_data_eff = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_data_eff[i*WIDTH +: WIDTH] = wr_broadcast ? WD_S : WD[i*WIDTH +: WIDTH];
    end
  end

  // Writes aimed at a hardwired zero register are dropped entirely.
  assign wr_allowed = wr_enable && !(ZERO_REG && (RD == '0));

  // Next register contents: only masked lanes of RD take the new data.
  always_comb begin
    regs_d = regs_q;
    if (wr_allowed) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) regs_d[RD][i*WIDTH +: WIDTH] = wr_data_eff[i*WIDTH +: WIDTH];
      end
    end
  end

  // Register storage; reset clears every register asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs_addr[0] = RS1;
  assign rs_addr[1] = RS2;
  assign rs_addr[2] = RS3;

  // Read ports. Lanes being written this cycle are forwarded from the write
  // port so a consumer sees the value before the edge. Reset forces zero so
  // an in-flight write cannot leak through the bypass while rst is high.
  for (genvar p = 0; p < 3; p++) begin : g_read
    always_comb begin
      rd_data[p] = '0;
      if (!rst && !(ZERO_REG && (rs_addr[p] == '0))) begin
        rd_data[p] = regs_q[rs_addr[p]];
        if (wr_enable && (RD == rs_addr[p])) begin
          for (int i = 0; i < LANES; i++) begin
            if (wr_mask[i]) rd_data[p][i*WIDTH +: WIDTH] = wr_data_eff[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign RD1 = rd_data[0];
  assign RD2 = rd_data[1];
  assign RD3 = rd_data[2];

  register_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clr_valid (wr_enable),
    .clr_addr  (RD),
    .set_valid (issue_valid),
    .set_addr  (issue_rd),
    .flush     (flush),
    .rs1       (RS1),
    .rs2       (RS2),
    .rs3       (RS3),
    .busy1     (busy1),
    .busy2     (busy2),
    .busy3     (busy3),
    .busy_rd   (busy_rd)
  );

endmodule
